// File: rtl/uart_pkg.sv
// UART transmit shared definitions.
// State encoding, default width and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int   DATA_WIDTH_DEF = 8;
  localparam logic LINE_IDLE      = 1'b1;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART TX shift register and bit counter.
// Counter tracks index of data bit on line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  RST_n,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] p_data,
  output logic                  ser_data,
  output logic                  ser_next,
  output logic                  ser_done
);

  localparam int CW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  // Load word or advance one bit.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = p_data;
      cnt_d   = '0;
    end else if (shift) begin
      shift_d = shift_q >> 1;
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // Shift and count registers.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ser_data = shift_q[0];
  assign ser_next = shift_q[1];
  assign ser_done = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX controller: accept word, frame it,
// drive line one bit per clock.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  RST_n,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  Par_bit,
  output logic                  LOAD,
  output logic                  TX_OUT,
  output logic                  Busy
);

  tx_state_e state_q, state_d;
  logic      tx_q, tx_d;
  logic      busy_q, busy_d;
  logic      par_en_q, par_en_d;
  logic      ser_load, ser_shift;
  logic      ser_data, ser_next, ser_done;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ser (
    .clk     (clk),
    .RST_n   (RST_n),
    .load    (ser_load),
    .shift   (ser_shift),
    .p_data  (P_DATA),
    .ser_data(ser_data),
    .ser_next(ser_next),
    .ser_done(ser_done)
  );

  // Next state; line and busy follow next state.
  always_comb begin
    state_d   = state_q;
    tx_d      = LINE_IDLE;
    busy_d    = 1'b1;
    par_en_d  = par_en_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          ser_load = 1'b1;
          par_en_d = PAR_EN;
          state_d  = START;
          tx_d     = START_BIT;
        end else begin
          busy_d = 1'b0;
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = ser_data;
      end
      DATA: begin
        if (ser_done) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = Par_bit;
          end else begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end
        end else begin
          ser_shift = 1'b1;
          tx_d      = ser_next;
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_BIT;
      end
      STOP: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= IDLE;
      tx_q     <= LINE_IDLE;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      par_en_q <= par_en_d;
    end
  end

  assign LOAD   = (state_q == IDLE);
  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller/serializer that sits directly beside the TX parity unit. It accepts an 8-bit word on a valid strobe and asserts LOAD so the parity unit registers Par_bit. It then serializes start bit, data bits LSB-first, optional parity bit and stop bit onto TX_OUT, one bit per clock. The clock is the TX bit-rate clock, and Busy flags frame-in-progress to the upstream system controller.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (counter width = clog2(DATA_WIDTH))

Ports:
clk  input  1  TX bit clock; all state changes on posedge
RST_n  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel data word, sampled only on acceptance
Data_Valid  input  1  word-valid strobe/level from upstream
PAR_EN  input  1  1 = insert parity bit; sampled on acceptance
Par_bit  input  1  parity bit from parity unit; valid from the cycle after LOAD&&Data_Valid
LOAD  output  1  to parity unit; combinational, high only while state==IDLE
TX_OUT  output  1  serial line, registered, idle-high
Busy  output  1  registered, high while a frame is on the line

Behaviour:
- Reset (async, RST_n low): state=IDLE, TX_OUT=1, Busy=0, shift reg=0, bit counter=0, par_en_q=0. Reset mid-frame aborts immediately; line returns high asynchronously. No partial frame resumes.
- States: IDLE, START, DATA, PARITY, STOP (3-bit encoding).
- Outputs are registered from the next state: TX_OUT/Busy during cycle k reflect the state entered at the edge ending cycle k-1.
- IDLE: LOAD=1. On an edge with Data_Valid=1: shift reg<=P_DATA, par_en_q<=PAR_EN, counter<=0, state->START, TX_OUT<=0, Busy<=1. With Data_Valid=0: hold, TX_OUT=1, Busy=0.
- START, one cycle: state->DATA, TX_OUT<=shift[0].
- DATA: on each edge, shift right and increment counter; TX_OUT<=next bit. After bit DATA_WIDTH-1 has been driven for one cycle:
  - par_en_q=1: state->PARITY, TX_OUT<=Par_bit.
  - par_en_q=0: state->STOP, TX_OUT<=1.
- PARITY, one cycle: state->STOP, TX_OUT<=1.
- STOP, one cycle: state->IDLE, TX_OUT<=1, Busy<=0.
- Frame length on line: 10 cycles without parity, 11 with parity. Busy is high for exactly those cycles.
- Latency: start bit appears the cycle after the accepting edge.
- Back-to-back: Data_Valid held high gives the next acceptance on the first IDLE edge. That leaves exactly one idle-high cycle between frames, in addition to the stop bit.
- Data_Valid, P_DATA and PAR_EN changes while Busy=1 are ignored. Input data is captured once, so later changes never corrupt the frame.
- Par_bit is sampled only in the DATA->PARITY transition. It is then stable, because the parity unit holds the value when LOAD=0.
- Counter wraps to 0 only via reload in IDLE; it never free-runs.

Decomposition:
- Shared package (uart_pkg): state encoding localparams (IDLE/START/DATA/PARITY/STOP), DATA_WIDTH default, line idle level (1), start/stop bit values.
- One sub-module: uart_tx_serializer, containing the shift register and bit counter with load/shift inputs and ser_data/ser_done outputs.
- The FSM, output mux and output registers stay in uart_tx_ctrl.

Test Plan:
1. Reset: RST_n low mid-DATA -> TX_OUT=1, Busy=0, LOAD=1 immediately. After release, the first Data_Valid frame is clean.
2. P_DATA=0xA5, PAR_EN=1, parity unit even -> line: 0,1,0,1,0,0,1,0,1,0(parity),1(stop); Busy high 11 cycles; LOAD low throughout.
3. P_DATA=0x01, PAR_EN=0 -> line: 0,1,0,0,0,0,0,0,0,1; Busy high 10 cycles; Par_bit ignored.
4. P_DATA=0x07, PAR_EN=1, parity unit odd -> parity bit 0, frame 11 cycles.
5. Data_Valid held high with P_DATA=0x3C then 0xC3 -> two frames separated by exactly one idle-high cycle. The second frame carries 0xC3 even though P_DATA changed mid-first-frame.
6. Data_Valid pulse while Busy=1 -> no effect; frame unchanged; no extra frame after STOP.
